// File: rtl/mac_mult_stage.sv
// mac_mult_stage: signed fixed-point multiply stage that feeds the accumulator.
// Two-stage pipeline (operand register, then multiply/round/scale) with
// acc_reset/o_we aligned to result, plus an IDLE/ACCUM sequencing FSM that
// counts terms per dot product and flags framing errors (sticky seq_err).
// Optional build macro: MAC_SATURATE_EN clamps the scaled product to the
// DWIDTH signed range; when undefined the product simply wraps on truncation.
module mac_mult_stage #(
  parameter int DWIDTH = 16,
  parameter int FRAC   = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DWIDTH-1:0] pixel,
  input  logic [DWIDTH-1:0] weight,
  input  logic              err_clr,
  output logic [DWIDTH-1:0] result,
  output logic              acc_reset,
  output logic              o_we,
  output logic [CWIDTH-1:0] nterms,
  output logic              busy,
  output logic              seq_err
);

  // One spare bit over the full product so adding the rounding constant never overflows.
  localparam int PW  = 2 * DWIDTH + 1;
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [PW-1:0] ROUND = (FRAC > 0) ? $signed(PW'(1) << RSH) : $signed(PW'(0));
  localparam logic signed [PW-1:0] SMAX  = $signed((PW'(1) << (DWIDTH - 1)) - PW'(1));
  localparam logic signed [PW-1:0] SMIN  = ~SMAX;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [CWIDTH-1:0]         cnt_q, cnt_d;
  logic                      seq_err_q, seq_err_d;
  logic signed [DWIDTH-1:0]  pix1_q, pix1_d, wt1_q, wt1_d;
  logic                      v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
  logic [CWIDTH-1:0]         nt1_q, nt1_d;
  logic                      ntld1_q, ntld1_d;
  logic [DWIDTH-1:0]         result_q, result_d;
  logic                      acc_reset_q, acc_reset_d, o_we_q, o_we_d;
  logic [CWIDTH-1:0]         nterms_q, nterms_d;

  logic signed [PW-1:0]      pix_ext, wt_ext, prod, scaled;
  logic [DWIDTH-1:0]         res_val;
  logic [CWIDTH-1:0]         cnt_inc;
  logic                      err_set;

  // Stage-2 arithmetic: full-precision product, round half up, rescale, narrow.
  always_comb begin
    pix_ext = {{(DWIDTH + 1){pix1_q[DWIDTH-1]}}, pix1_q};
    wt_ext  = {{(DWIDTH + 1){wt1_q[DWIDTH-1]}}, wt1_q};
    prod    = pix_ext * wt_ext;
    scaled  = (prod + ROUND) >>> FRAC;
`ifdef MAC_SATURATE_EN
    if (scaled > SMAX)      res_val = SMAX[DWIDTH-1:0];
    else if (scaled < SMIN) res_val = SMIN[DWIDTH-1:0];
    else                    res_val = scaled[DWIDTH-1:0];
`else
    res_val = scaled[DWIDTH-1:0];
`endif
  end

  // Sequencing FSM next state: term counting, framing errors, nterms capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    ntld1_d = 1'b0;
    nt1_d   = nt1_q;
    cnt_inc = (cnt_q == {CWIDTH{1'b1}}) ? cnt_q : cnt_q + CWIDTH'(1);
    if (in_valid) begin
      if (in_first) begin
        // A first inside an open sum is a restart: flag it and count from 1.
        err_set = (state_q == ACCUM);
        if (in_last) begin
          state_d = IDLE;
          cnt_d   = '0;
          ntld1_d = 1'b1;
          nt1_d   = CWIDTH'(1);
        end else begin
          state_d = ACCUM;
          cnt_d   = CWIDTH'(1);
        end
      end else if (state_q == IDLE) begin
        // Orphan term with no opening first: pass it through as a lone term.
        err_set = 1'b1;
        if (in_last) begin
          ntld1_d = 1'b1;
          nt1_d   = CWIDTH'(1);
        end
      end else if (in_last) begin
        state_d = IDLE;
        cnt_d   = '0;
        ntld1_d = 1'b1;
        nt1_d   = cnt_inc;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    // A fresh error in the same cycle as a clear keeps the flag set.
    seq_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : seq_err_q);
  end

  // Pipeline next state: operand capture, then aligned result/controls/nterms.
  always_comb begin
    pix1_d      = pixel;
    wt1_d       = weight;
    v1_d        = in_valid;
    first1_d    = in_first;
    last1_d     = in_last;
    result_d    = v1_q ? res_val : '0;
    acc_reset_d = v1_q & first1_q;
    o_we_d      = v1_q & last1_q;
    nterms_d    = ntld1_q ? nt1_q : nterms_q;
  end

  // All state, asynchronously cleared so an aborted sum never produces o_we.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      seq_err_q   <= 1'b0;
      pix1_q      <= '0;
      wt1_q       <= '0;
      v1_q        <= 1'b0;
      first1_q    <= 1'b0;
      last1_q     <= 1'b0;
      nt1_q       <= '0;
      ntld1_q     <= 1'b0;
      result_q    <= '0;
      acc_reset_q <= 1'b0;
      o_we_q      <= 1'b0;
      nterms_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_err_q   <= seq_err_d;
      pix1_q      <= pix1_d;
      wt1_q       <= wt1_d;
      v1_q        <= v1_d;
      first1_q    <= first1_d;
      last1_q     <= last1_d;
      nt1_q       <= nt1_d;
      ntld1_q     <= ntld1_d;
      result_q    <= result_d;
      acc_reset_q <= acc_reset_d;
      o_we_q      <= o_we_d;
      nterms_q    <= nterms_d;
    end
  end

  assign result    = result_q;
  assign acc_reset = acc_reset_q;
  assign o_we      = o_we_q;
  assign nterms    = nterms_q;
  assign busy      = (state_q == ACCUM);
  assign seq_err   = seq_err_q;

endmodule
